// File: rtl/sram_bus_arbiter_pkg.sv
// sram_bus_arbiter_pkg: shared owner/size codes, FIFO sizing and the tag entry type
package sram_bus_arbiter_pkg;
    localparam int OUTST_DEPTH = 4;
    localparam int PTR_W = 2;
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    typedef struct packed {
        logic owner;
        logic drop;
    } tag_t;
endpackage

// File: rtl/sram_bus_arbiter_if.sv
// sram_bus_arbiter_if: inst port, data port and shared bus signals of the arbiter
interface sram_bus_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_cancel;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        outst_full;
    logic        err_unexp;
    modport slave (
        input  inst_req, inst_addr, inst_cancel, data_req, data_wr, data_size, data_addr, data_wdata,
               bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
               bus_req, bus_wr, bus_size, bus_addr, bus_wdata, outst_full, err_unexp
    );
    modport master (
        output inst_req, inst_addr, inst_cancel, data_req, data_wr, data_size, data_addr, data_wdata,
               bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
               bus_req, bus_wr, bus_size, bus_addr, bus_wdata, outst_full, err_unexp
    );
endinterface

// File: rtl/sram_bus_arbiter_tag_fifo.sv
// arb_tag_fifo: in-order {owner,drop} tags of accepted requests awaiting a bus response
module arb_tag_fifo
    import sram_bus_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_owner,
    input  logic pop,
    input  logic mark_inst_drop,
    output tag_t head,
    output logic empty,
    output logic full
);
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    tag_t             mem_q [OUTST_DEPTH];
    tag_t             mem_d [OUTST_DEPTH];
    // cancel marks every inst tag (stale slots too, harmless) including one pushed this cycle
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < OUTST_DEPTH; i++)
            if (mark_inst_drop && mem_q[i].owner == OWNER_INST) mem_d[i].drop = 1'b1;
        if (push) mem_d[wr_q] = '{owner: push_owner, drop: mark_inst_drop && push_owner == OWNER_INST};
        wr_d = wr_q + PTR_W'(push);
        rd_d = rd_q + PTR_W'(pop);
        cnt_d = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
    // pointer, count and storage registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < OUTST_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end
    assign head = mem_q[rd_q];
    assign empty = cnt_q == '0;
    assign full = cnt_q == (PTR_W+1)'(OUTST_DEPTH);
endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one split-handshake bus between fetch and data ports
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    sram_bus_arbiter_if.slave io
);
    logic lock_q, lock_d, lock_owner_q, lock_owner_d, err_q, err_d;
    logic owner, owner_req, bus_req, accept, pop, empty, full;
    tag_t head;
    // owner select with request lock; a cancelled inst request is withdrawn and drops its lock
    always_comb begin
        owner = lock_q ? lock_owner_q : (io.data_req ? OWNER_DATA : OWNER_INST);
        owner_req = owner == OWNER_DATA ? io.data_req : io.inst_req && !io.inst_cancel;
        bus_req = owner_req && !full;
        accept = bus_req && io.bus_addr_ok;
        pop = io.bus_data_ok && !empty;
        lock_d = bus_req && !io.bus_addr_ok;
        lock_owner_d = owner;
        err_d = err_q || (io.bus_data_ok && empty);
    end
    // lock and sticky unexpected-response flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q <= 1'b0;
            lock_owner_q <= OWNER_INST;
            err_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
            lock_owner_q <= lock_owner_d;
            err_q <= err_d;
        end
    end
    arb_tag_fifo u_fifo (
        .clk(clk),
        .reset(reset),
        .push(accept),
        .push_owner(owner),
        .pop(pop),
        .mark_inst_drop(io.inst_cancel),
        .head(head),
        .empty(empty),
        .full(full)
    );
    assign io.bus_req = bus_req;
    assign io.bus_wr = owner == OWNER_DATA && io.data_wr;
    assign io.bus_size = owner == OWNER_DATA ? io.data_size : SIZE_WORD;
    assign io.bus_addr = owner == OWNER_DATA ? io.data_addr : io.inst_addr;
    assign io.bus_wdata = owner == OWNER_DATA ? io.data_wdata : '0;
    assign io.inst_addr_ok = accept && owner == OWNER_INST;
    assign io.data_addr_ok = accept && owner == OWNER_DATA;
    assign io.inst_data_ok = pop && head.owner == OWNER_INST && !head.drop && !io.inst_cancel;
    assign io.data_data_ok = pop && head.owner == OWNER_DATA;
    assign io.inst_rdata = io.bus_rdata;
    assign io.data_rdata = io.bus_rdata;
    assign io.outst_full = full;
    assign io.err_unexp = err_q;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed and random stimulus against a queue-based reference model
module tb_sram_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    sram_bus_arbiter_if ifc();
    sram_bus_arbiter dut (.clk(clk), .reset(reset), .io(ifc));
    always #5 clk = ~clk;
    typedef struct {
        bit own;
        bit drop;
    } ent_t;
    ent_t q[$];
    bit lk_v, lk_o, err_m, acc_i, acc_d;
    int vectors = 0;
    int miscompares = 0;
    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask
    task automatic drive(bit ir, logic [31:0] ia, bit dr, logic [31:0] da, bit cn, bit ao, bit dok, logic [31:0] rd);
        ifc.inst_req = ir;
        ifc.inst_addr = ia;
        ifc.data_req = dr;
        ifc.data_addr = da;
        ifc.inst_cancel = cn;
        ifc.bus_addr_ok = ao;
        ifc.bus_data_ok = dok;
        ifc.bus_rdata = rd;
    endtask
    task automatic do_reset();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        ifc.data_wr = 0;
        ifc.data_size = 2;
        ifc.data_wdata = 0;
        q.delete();
        lk_v = 0;
        lk_o = 0;
        err_m = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bus_req", ifc.bus_req, 0);
        chk("rst_inst_addr_ok", ifc.inst_addr_ok, 0);
        chk("rst_data_addr_ok", ifc.data_addr_ok, 0);
        chk("rst_inst_data_ok", ifc.inst_data_ok, 0);
        chk("rst_data_data_ok", ifc.data_data_ok, 0);
        chk("rst_full", ifc.outst_full, 0);
        chk("rst_err", ifc.err_unexp, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask
    // one clock: check outputs against the model, then advance the model at the edge
    task automatic cycle();
        bit sel, rq, brq, acc, pop, emp, cn;
        ent_t h, e;
        #1;
        cn = ifc.inst_cancel;
        sel = lk_v ? lk_o : ifc.data_req;
        rq = sel ? ifc.data_req : (ifc.inst_req && !cn);
        brq = rq && q.size() < 4;
        acc = brq && ifc.bus_addr_ok;
        emp = q.size() == 0;
        pop = ifc.bus_data_ok && !emp;
        h.own = 0;
        h.drop = 0;
        if (pop) h = q[0];
        chk("bus_req", ifc.bus_req, brq);
        if (brq) begin
            chk("bus_addr", ifc.bus_addr, sel ? ifc.data_addr : ifc.inst_addr);
            chk("bus_wr", ifc.bus_wr, sel ? ifc.data_wr : 0);
            chk("bus_size", ifc.bus_size, sel ? ifc.data_size : 2);
        end
        chk("inst_addr_ok", ifc.inst_addr_ok, acc && !sel);
        chk("data_addr_ok", ifc.data_addr_ok, acc && sel);
        chk("inst_data_ok", ifc.inst_data_ok, pop && !h.own && !h.drop && !cn);
        chk("data_data_ok", ifc.data_data_ok, pop && h.own);
        chk("outst_full", ifc.outst_full, q.size() == 4);
        chk("err_unexp", ifc.err_unexp, err_m);
        chk("inst_rdata", ifc.inst_rdata, ifc.bus_rdata);
        chk("data_rdata", ifc.data_rdata, ifc.bus_rdata);
        acc_i = acc && !sel;
        acc_d = acc && sel;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (cn) foreach (q[k]) if (!q[k].own) q[k].drop = 1;
        if (acc) begin
            e.own = sel;
            e.drop = cn && !sel;
            q.push_back(e);
        end
        lk_v = brq && !ifc.bus_addr_ok;
        lk_o = sel;
        if (ifc.bus_data_ok && emp) err_m = 1;
        @(negedge clk);
    endtask
    initial begin
        bit cn;
        do_reset();
        // single inst fetch, response two cycles after accept
        drive(1, 32'h1000, 0, 0, 0, 1, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h2402_0001); cycle();
        // simultaneous requests: data first, then inst; responses in order
        drive(1, 32'h2000, 1, 32'h3000, 0, 1, 0, 0); cycle();
        drive(1, 32'h2000, 0, 0, 0, 1, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 32'hAAAA_0001); cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 32'hBBBB_0002); cycle();
        // locked inst request holds the bus while data waits
        drive(1, 32'h4000, 0, 0, 0, 0, 0, 0); cycle();
        drive(1, 32'h4000, 1, 32'h5000, 0, 0, 0, 0); cycle();
        drive(1, 32'h4000, 1, 32'h5000, 0, 0, 0, 0); cycle();
        drive(1, 32'h4000, 1, 32'h5000, 0, 1, 0, 0); cycle();
        drive(0, 0, 1, 32'h5000, 0, 1, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h1111); cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h2222); cycle();
        // two inst + one data in flight, cancel, three responses
        drive(1, 32'h6000, 0, 0, 0, 1, 0, 0); cycle();
        drive(1, 32'h6004, 0, 0, 0, 1, 0, 0); cycle();
        drive(0, 0, 1, 32'h7000, 0, 1, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 0, 0, 0); cycle();
        repeat (3) begin drive(0, 0, 0, 0, 0, 0, 1, 32'h3333); cycle(); end
        // fill to four outstanding, stall while full, resume after one response
        for (int i = 0; i < 4; i++) begin drive(0, 0, 1, 32'h8000 + i * 4, 0, 1, 0, 0); cycle(); end
        drive(0, 0, 1, 32'h9000, 0, 1, 0, 0); cycle();
        drive(0, 0, 1, 32'h9000, 0, 1, 1, 32'h4444); cycle();
        drive(0, 0, 1, 32'h9000, 0, 1, 0, 0); cycle();
        repeat (4) begin drive(0, 0, 0, 0, 0, 0, 1, 32'h5555); cycle(); end
        // response with nothing outstanding sets the sticky error until reset
        drive(0, 0, 0, 0, 0, 0, 1, 32'h6666); cycle();
        repeat (2) begin drive(0, 0, 0, 0, 0, 0, 0, 0); cycle(); end
        do_reset();
        // random traffic obeying the hold-while-waiting rule, with a reset midway
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) do_reset();
            cn = ($urandom % 20) == 0;
            if (!ifc.inst_req) begin
                ifc.inst_req = ($urandom % 3) == 0;
                ifc.inst_addr = $urandom;
            end
            if (!ifc.data_req) begin
                ifc.data_req = ($urandom % 3) == 0;
                ifc.data_addr = $urandom;
                ifc.data_wr = $urandom % 2;
                ifc.data_size = 2'($urandom % 3);
                ifc.data_wdata = $urandom;
            end
            ifc.inst_cancel = cn;
            ifc.bus_addr_ok = $urandom % 2;
            ifc.bus_data_ok = q.size() != 0 ? 1'($urandom % 2) : 1'(($urandom % 300) == 0);
            ifc.bus_rdata = $urandom;
            cycle();
            if (acc_i || cn) ifc.inst_req = 0;
            if (acc_d) ifc.data_req = 0;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
